// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the element FIFOs on the prefetch path and the dispatch
// queues that reuse the lane window.
//   cnt_w(n)      : bits needed to hold a count in 0..n
//   ptr_w(d)      : bits needed to index a d-entry ring (minimum 1)
//   lane_lsb(l,w) : LSB position of lane l in a packed bus of w-bit lanes
//   elem_t        : default 18-bit prefetch element
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int LINE_DEF = 18;

  typedef logic [LINE_DEF-1:0] elem_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int line);
    return lane * line;
  endfunction

endpackage

// File: rtl/fifo_lane_window.sv
// ---------------------------------------------------------------------------
// fifo_lane_window
// Combinational circular read window: exposes POP_W consecutive entries of a
// DEPTH-entry ring starting at rd_ptr, wrapping modulo DEPTH. Lane 0 is the
// entry at rd_ptr (the oldest).
// Ports:
//   mem     in  DEPTH x LINE storage array
//   rd_ptr  in  ring index of the oldest entry
//   window  out POP_W*LINE, lane i in bits [i*LINE +: LINE]
// ---------------------------------------------------------------------------
module fifo_lane_window
  import fifo_pkg::*;
#(
  parameter int LINE  = 18,
  parameter int DEPTH = 64,
  parameter int POP_W = 2,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic [LINE-1:0]       mem [DEPTH],
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [POP_W*LINE-1:0] window
);

  logic [PTR_W-1:0] idx;

  // Index arithmetic is kept at PTR_W bits so it wraps at DEPTH by itself.
  always_comb begin
    window = '0;
    idx    = '0;
    for (int i = 0; i < POP_W; i++) begin
      idx = rd_ptr + PTR_W'(i);
      window[lane_lsb(i, LINE) +: LINE] = mem[idx];
    end
  end

endmodule

// File: rtl/superscalar_stream_fifo.sv
// ---------------------------------------------------------------------------
// superscalar_stream_fifo
// Element-granular multi-push / multi-pop FIFO between the prefetch-initiate
// decoder (up to PUSH_W pushes per cycle) and the DMA request issuer (up to
// POP_W pops per cycle). Pushes are all-or-nothing, judged against the
// pre-edge occupancy; pops are clamped to the current occupancy.
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   push_count    elements offered this cycle (lanes 0..push_count-1 valid)
//   push_data     PUSH_W*LINE, lane 0 (oldest) in [LINE-1:0]
//   push_ok       comb: free space >= push_count
//   pop_count     elements the consumer takes this cycle
//   pop_data      show-ahead view of the oldest POP_W elements
//   pop_valid     bit i set when i < count
//   pop_taken     comb: min(pop_count, count)
//   count         registered occupancy
//   full_soon     registered: free < SOON+PUSH_W
//   empty_soon    registered: count <= SOON
//   err_overflow  sticky: a push was offered while push_ok was low
// ---------------------------------------------------------------------------
module superscalar_stream_fifo
  import fifo_pkg::*;
#(
  parameter int LINE   = 18,
  parameter int PUSH_W = 4,
  parameter int POP_W  = 2,
  parameter int DEPTH  = 64,
  parameter int SOON   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [cnt_w(PUSH_W)-1:0]   push_count,
  input  logic [PUSH_W*LINE-1:0]     push_data,
  output logic                       push_ok,
  input  logic [cnt_w(POP_W)-1:0]    pop_count,
  output logic [POP_W*LINE-1:0]      pop_data,
  output logic [POP_W-1:0]           pop_valid,
  output logic [cnt_w(POP_W)-1:0]    pop_taken,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       full_soon,
  output logic                       empty_soon,
  output logic                       err_overflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PC_W  = cnt_w(PUSH_W);
  localparam int OC_W  = cnt_w(POP_W);

  logic [LINE-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] push_add;
  logic [CNT_W-1:0] count_next;
  logic             full_next;
  logic             empty_next;

  // Admission uses pre-edge occupancy only: a same-cycle pop never makes room.
  assign free      = CNT_W'(DEPTH) - count;
  assign push_ok   = free >= CNT_W'(push_count);
  assign push_add  = push_ok ? CNT_W'(push_count) : '0;
  assign pop_taken = (CNT_W'(pop_count) > count) ? OC_W'(count) : pop_count;

  assign count_next = count + push_add - CNT_W'(pop_taken);
  assign full_next  = (DEPTH - int'(count_next)) < (SOON + PUSH_W);
  assign empty_next = int'(count_next) <= SOON;

  always_comb begin
    pop_valid = '0;
    for (int i = 0; i < POP_W; i++) begin
      pop_valid[i] = CNT_W'(i) < count;
    end
  end

  // Control state: pointers, occupancy, flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full_soon    <= 1'b0;
      empty_soon   <= 1'b1;
      err_overflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push_add);
      rd_ptr     <= rd_ptr + PTR_W'(pop_taken);
      count      <= count_next;
      full_soon  <= full_next;
      empty_soon <= empty_next;
      if ((push_count != '0) && !push_ok) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Write-lane scatter: lane i lands at wr_ptr+i, wrapping at DEPTH.
  // Storage is not cleared by reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (!reset && push_ok && (PC_W'(i) < push_count)) begin
        mem[wr_ptr + PTR_W'(i)] <= push_data[lane_lsb(i, LINE) +: LINE];
      end
    end
  end

  fifo_lane_window #(
    .LINE  (LINE),
    .DEPTH (DEPTH),
    .POP_W (POP_W)
  ) u_window (
    .mem    (mem),
    .rd_ptr (rd_ptr),
    .window (pop_data)
  );

endmodule

// File: tb/tb_superscalar_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_superscalar_stream_fifo
// Scoreboard bench: every accepted push appends its lanes to a queue, and the
// show-ahead lanes are compared against the queue head before each pop.
// ---------------------------------------------------------------------------
module tb_superscalar_stream_fifo;

  localparam int LINE   = 18;
  localparam int PUSH_W = 4;
  localparam int POP_W  = 2;
  localparam int DEPTH  = 64;
  localparam int SOON   = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [2:0]             push_count = '0;
  logic [PUSH_W*LINE-1:0] push_data = '0;
  logic                   push_ok;
  logic [1:0]             pop_count = '0;
  logic [POP_W*LINE-1:0]  pop_data;
  logic [POP_W-1:0]       pop_valid;
  logic [1:0]             pop_taken;
  logic [6:0]             count;
  logic                   full_soon;
  logic                   empty_soon;
  logic                   err_overflow;

  superscalar_stream_fifo #(
    .LINE(LINE), .PUSH_W(PUSH_W), .POP_W(POP_W), .DEPTH(DEPTH), .SOON(SOON)
  ) dut (
    .clk(clk), .reset(rst),
    .push_count(push_count), .push_data(push_data), .push_ok(push_ok),
    .pop_count(pop_count), .pop_data(pop_data), .pop_valid(pop_valid),
    .pop_taken(pop_taken), .count(count), .full_soon(full_soon),
    .empty_soon(empty_soon), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (push_count <= 3'(PUSH_W) && pop_count <= 2'(POP_W))
      else $error("illegal push_count/pop_count driven");
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  logic [LINE-1:0] sb [$];
  logic [LINE-1:0] pd [PUSH_W];
  logic            err_m = 1'b0;
  logic            exp_ok;
  logic            snap_ok;
  int              exp_taken;
  int              snap_taken;

  // Drive one cycle of stimulus, capture the combinational outputs before the
  // edge, then advance the reference model across the edge.
  task automatic step(input int pc, input int oc);
    int sz;
    int tk;
    push_count = 3'(pc);
    pop_count  = 2'(oc);
    for (int i = 0; i < PUSH_W; i++) push_data[i*LINE +: LINE] = pd[i];
    #1;
    sz         = sb.size();
    exp_ok     = ((DEPTH - sz) >= pc);
    tk         = (oc < sz) ? oc : sz;
    exp_taken  = tk;
    snap_ok    = push_ok;
    snap_taken = int'(pop_taken);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      err_m = 1'b0;
    end else begin
      for (int i = 0; i < tk; i++) void'(sb.pop_front());
      if (exp_ok) begin
        for (int i = 0; i < pc; i++) sb.push_back(pd[i]);
      end else if (pc > 0) begin
        err_m = 1'b1;
      end
    end
    #1;
    push_count = '0;
    pop_count  = '0;
  endtask

  task automatic rand_pd();
    for (int i = 0; i < PUSH_W; i++) pd[i] = LINE'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0);
    step(0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 7'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
    total++; if (pop_valid !== 2'b00) begin bad++; $display("FAIL reset_pop_valid got %b want 00", pop_valid); end
    total++; if (push_ok !== 1'b1) begin bad++; $display("FAIL reset_push_ok got %b want 1", push_ok); end
    total++; if (full_soon !== 1'b0) begin bad++; $display("FAIL reset_full_soon got %b want 0", full_soon); end
    total++; if (empty_soon !== 1'b1) begin bad++; $display("FAIL reset_empty_soon got %b want 1", empty_soon); end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err_overflow); end
  endtask

  task automatic test_basic();
    pd[0] = 18'h0A0A1; pd[1] = 18'h0B0B2; pd[2] = 18'h0C0C3; pd[3] = 18'h3FFFF;
    step(3, 0);
    total++; if (count !== 7'd3) begin bad++; $display("FAIL basic_count got %0d want 3", count); end
    total++; if (pop_valid !== 2'b11) begin bad++; $display("FAIL basic_pop_valid got %b want 11", pop_valid); end
    total++; if (pop_data[17:0] !== 18'h0A0A1) begin bad++; $display("FAIL basic_lane0 got %h want 0a0a1", pop_data[17:0]); end
    total++; if (pop_data[35:18] !== 18'h0B0B2) begin bad++; $display("FAIL basic_lane1 got %h want 0b0b2", pop_data[35:18]); end
    total++; if (empty_soon !== 1'b1) begin bad++; $display("FAIL basic_empty_soon got %b want 1", empty_soon); end
    while (sb.size() > 0) begin
      for (int i = 0; i < POP_W && i < sb.size(); i++) begin
        total++;
        if (pop_data[i*LINE +: LINE] !== sb[i]) begin
          bad++; $display("FAIL basic_drain_lane%0d got %h want %h", i, pop_data[i*LINE +: LINE], sb[i]);
        end
      end
      step(0, 2);
    end
    total++; if (count !== 7'd0) begin bad++; $display("FAIL basic_drained got %0d want 0", count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 16; k++) begin rand_pd(); step(4, 0); end
    total++; if (count !== 7'd64) begin bad++; $display("FAIL fill_count got %0d want 64", count); end
    total++; if (full_soon !== 1'b1) begin bad++; $display("FAIL fill_full_soon got %b want 1", full_soon); end
    push_count = 3'd1; #1;
    total++; if (push_ok !== 1'b0) begin bad++; $display("FAIL fill_push_ok got %b want 0", push_ok); end
    rand_pd(); step(1, 0);
    total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL fill_err got %b want 1", err_overflow); end
    total++; if (count !== 7'd64) begin bad++; $display("FAIL fill_count_hold got %0d want 64", count); end
    // A full FIFO still refuses a push even while it pops.
    rand_pd(); step(1, 2);
    total++; if (snap_ok !== 1'b0) begin bad++; $display("FAIL full_pop_push_ok got %b want 0", snap_ok); end
    total++; if (count !== 7'd62) begin bad++; $display("FAIL full_pop_count got %0d want 62", count); end
    while (sb.size() > 0) begin
      for (int i = 0; i < POP_W && i < sb.size(); i++) begin
        total++;
        if (pop_data[i*LINE +: LINE] !== sb[i]) begin
          bad++; $display("FAIL fill_drain_lane%0d got %h want %h", i, pop_data[i*LINE +: LINE], sb[i]);
        end
      end
      step(0, 2);
    end
    total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL fill_err_sticky got %b want 1", err_overflow); end
  endtask

  task automatic test_clamp();
    do_reset();
    pd[0] = 18'h12345; step(1, 0);
    step(0, 2);
    total++; if (snap_taken !== 1) begin bad++; $display("FAIL clamp_taken got %0d want 1", snap_taken); end
    total++; if (count !== 7'd0) begin bad++; $display("FAIL clamp_count got %0d want 0", count); end
    total++; if (pop_valid !== 2'b00) begin bad++; $display("FAIL clamp_pop_valid got %b want 00", pop_valid); end
    total++; if (empty_soon !== 1'b1) begin bad++; $display("FAIL clamp_empty_soon got %b want 1", empty_soon); end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL clamp_err got %b want 0", err_overflow); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 15; k++) begin rand_pd(); step(4, 0); end
    rand_pd(); step(2, 0);
    for (int k = 0; k < 31; k++) step(0, 2);
    total++; if (count !== 7'd0) begin bad++; $display("FAIL wrap_walk_count got %0d want 0", count); end
    // Both pointers now sit at 62; this push straddles 63 -> 0.
    pd[0] = 18'h10001; pd[1] = 18'h20002; pd[2] = 18'h30003; pd[3] = 18'h04004;
    step(4, 0);
    // Pop one first so a later two-lane pop straddles 63 -> 0 as well.
    total++; if (pop_data[17:0] !== 18'h10001) begin bad++; $display("FAIL wrap_head got %h want 10001", pop_data[17:0]); end
    step(0, 1);
    while (sb.size() > 0) begin
      for (int i = 0; i < POP_W && i < sb.size(); i++) begin
        total++;
        if (pop_data[i*LINE +: LINE] !== sb[i]) begin
          bad++; $display("FAIL wrap_lane%0d got %h want %h", i, pop_data[i*LINE +: LINE], sb[i]);
        end
      end
      step(0, 2);
    end
  endtask

  task automatic test_simul();
    do_reset();
    rand_pd(); step(4, 0);
    rand_pd(); step(4, 0);
    rand_pd(); step(2, 0);
    total++; if (pop_data[17:0] !== sb[0] || pop_data[35:18] !== sb[1]) begin
      bad++; $display("FAIL simul_head got %h want %h%h", pop_data, sb[1], sb[0]);
    end
    rand_pd(); step(4, 2);
    total++; if (count !== 7'd12) begin bad++; $display("FAIL simul_count got %0d want 12", count); end
    while (sb.size() > 0) begin
      for (int i = 0; i < POP_W && i < sb.size(); i++) begin
        total++;
        if (pop_data[i*LINE +: LINE] !== sb[i]) begin
          bad++; $display("FAIL simul_lane%0d got %h want %h", i, pop_data[i*LINE +: LINE], sb[i]);
        end
      end
      step(0, 2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 10; k++) begin rand_pd(); step(4, 0); end
    total++; if (count !== 7'd40) begin bad++; $display("FAIL midrst_pre got %0d want 40", count); end
    rst = 1'b1; rand_pd(); step(4, 1);
    rst = 1'b0;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL midrst_count got %0d want 0", count); end
    total++; if (pop_valid !== 2'b00) begin bad++; $display("FAIL midrst_pop_valid got %b want 00", pop_valid); end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL midrst_err got %b want 0", err_overflow); end
    step(0, 0);
    total++; if (count !== 7'd0) begin bad++; $display("FAIL midrst_not_stored got %0d want 0", count); end
    pd[0] = 18'h2AAAA; step(1, 0);
    total++; if (pop_data[17:0] !== 18'h2AAAA) begin bad++; $display("FAIL midrst_ptr0 got %h want 2aaaa", pop_data[17:0]); end
    step(0, 1);
  endtask

  task automatic test_back_to_back();
    int pc;
    int oc;
    logic [1:0] vexp;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      pc = $urandom_range(0, 4);
      oc = (k > 200) ? 2 : $urandom_range(0, 2);
      for (int i = 0; i < POP_W && i < sb.size(); i++) begin
        total++;
        if (pop_data[i*LINE +: LINE] !== sb[i]) begin
          bad++; $display("FAIL b2b_lane%0d cyc %0d got %h want %h", i, k, pop_data[i*LINE +: LINE], sb[i]);
        end
      end
      rand_pd();
      step(pc, oc);
      total++; if (snap_ok !== exp_ok) begin bad++; $display("FAIL b2b_push_ok cyc %0d got %b want %b", k, snap_ok, exp_ok); end
      total++; if (snap_taken !== exp_taken) begin bad++; $display("FAIL b2b_taken cyc %0d got %0d want %0d", k, snap_taken, exp_taken); end
      total++; if (int'(count) !== sb.size()) begin bad++; $display("FAIL b2b_count cyc %0d got %0d want %0d", k, count, sb.size()); end
      total++; if (full_soon !== ((DEPTH - sb.size()) < (SOON + PUSH_W))) begin bad++; $display("FAIL b2b_full_soon cyc %0d got %b", k, full_soon); end
      total++; if (empty_soon !== (sb.size() <= SOON)) begin bad++; $display("FAIL b2b_empty_soon cyc %0d got %b", k, empty_soon); end
      total++; if (err_overflow !== err_m) begin bad++; $display("FAIL b2b_err cyc %0d got %b want %b", k, err_overflow, err_m); end
      vexp = (sb.size() >= 2) ? 2'b11 : (sb.size() == 1) ? 2'b01 : 2'b00;
      total++; if (pop_valid !== vexp) begin bad++; $display("FAIL b2b_pop_valid cyc %0d got %b want %b", k, pop_valid, vexp); end
    end
  endtask

  initial begin
    for (int i = 0; i < PUSH_W; i++) pd[i] = '0;
    test_reset();
    test_basic();
    test_fill();
    test_clamp();
    test_wrap();
    test_simul();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/superscalar_stream_fifo.md
Name: superscalar_stream_fifo

Overview:
- Generalised multi-push / multi-pop element FIFO for the prefetch path; successor to the fixed 4-push/1-pop packed-line FIFO.
- Stores individual elements, not packed lines, so occupancy is exact and pops may span push groups.
- Sits between the prefetch-initiate decoder (producer, up to PUSH_W per cycle) and the DMA request issuer (consumer, up to POP_W per cycle).

Parameters:
- LINE, 18, element width in bits.
- PUSH_W, 4, max elements pushed per cycle (>=1).
- POP_W, 2, max elements popped per cycle (>=1).
- DEPTH, 64, element capacity; power of 2, >= PUSH_W+POP_W.
- SOON, 4, threshold slack for full_soon/empty_soon.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- push_count  in  $clog2(PUSH_W+1)  elements offered this cycle (0..PUSH_W); lane i valid iff i<push_count.
- push_data  in  PUSH_W*LINE  lane 0 in bits [LINE-1:0]; lane 0 is oldest.
- push_ok  out  1  combinational; 1 iff free >= push_count.
- pop_count  in  $clog2(POP_W+1)  elements the consumer takes this cycle (0..POP_W).
- pop_data  out  POP_W*LINE  show-ahead view of the oldest POP_W elements; lane 0 is oldest.
- pop_valid  out  POP_W  bit i = (i < count).
- pop_taken  out  $clog2(POP_W+1)  combinational; min(pop_count, count).
- count  out  $clog2(DEPTH+1)  registered occupancy.
- full_soon  out  1  registered; free < SOON+PUSH_W.
- empty_soon  out  1  registered; count <= SOON.
- err_overflow  out  1  sticky; set when push_count>0 and !push_ok.

Behaviour:
- State:
  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count register.
  - DEPTH x LINE storage.
- Reset values: pointers 0; count 0; pop_valid 0; push_ok 1; full_soon 0; empty_soon 1; err_overflow 0.
- Reset mid-operation discards all contents. Push and pop inputs are ignored in the reset cycle.
- Push:
  - All-or-nothing. If push_ok, lanes 0..push_count-1 are written to mem[wr_ptr+i mod DEPTH] at the clock edge, and wr_ptr advances by push_count.
  - If !push_ok, nothing is written, pointers hold, and err_overflow sets.
  - Free space is evaluated from pre-edge count only. A same-cycle pop does not make room.
- Pop:
  - pop_data lane i = mem[rd_ptr+i mod DEPTH], combinational from registered state.
  - rd_ptr advances by pop_taken. Requesting more than count is legal and is clamped, with no error.
- Latency: an element pushed at edge N is visible on pop_data/pop_valid after edge N. There is no same-cycle bypass; empty stays empty for the push cycle.
- Simultaneous push and pop:
  - count_next = count + (push_ok ? push_count : 0) - pop_taken.
  - Popped elements always predate pushed ones.
  - A full FIFO with pop_taken>0 still rejects a push that cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH. Pushes and pops may straddle index DEPTH-1 -> 0 within one cycle.
- Flags:
  - full_soon and empty_soon are computed from count_next and registered.
  - They may both be 1 only when DEPTH <= 2*SOON+PUSH_W.
- Ordering: strict FIFO across lanes and cycles.
- Out-of-range inputs: push_count>PUSH_W or pop_count>POP_W are illegal. The bench asserts on them; RTL behaviour is undefined.

Decomposition:
- Shared package fifo_pkg holds:
  - width helpers: cnt_w(n) = $clog2(n+1), ptr_w(d).
  - a packed-lane typedef helper for LINE-wide elements.
- One sub-module, fifo_lane_window: a POP_W-output circular read window over the storage, indexed by rd_ptr. It is reused by future dispatch queues.
- Write-lane scatter stays inline.

Test Plan:
1. Reset, then push_count=3 with data A,B,C, pop_count=0 -> next cycle count=3, pop_valid=2'b11, pop_data lanes = A,B; empty_soon=1.
2. Fill 64 elements with 16 pushes of 4 -> count=64, push_ok=0 with push_count=1, full_soon=1. Push 1 more -> rejected, err_overflow=1, count stays 64.
3. count=1, pop_count=2 -> pop_taken=1; next cycle count=0, pop_valid=0, empty_soon=1, no error.
4. Walk pointers to wr_ptr=62, then push 4 -> indices 62,63,0,1 written. Pop 2 per cycle -> exact push order returned across the wrap.
5. count=10, push 4 and pop 2 same cycle -> count=12; old head pair popped, new elements appended after existing tail.
6. Assert reset while count=40 with push_count=4 -> next cycle count=0, pointers 0, err_overflow=0, pushed lanes not stored.
